// File: rtl/mash11_dsm_if.sv
// Stream bundle for mash11_dsm: AXI-Stream style sample input with ready,
// valid-only modulator code output.
interface mash11_dsm_if #(
    parameter int WIDTH  = 16,
    parameter int DAC_BW = 4
);
    logic [WIDTH-1:0]  s_axis_data_tdata;
    logic              s_axis_data_tvalid;
    logic              s_axis_data_tready;
    logic [DAC_BW-1:0] m_axis_data_tdata;
    logic              m_axis_data_tvalid;

    // slave: the modulator side; master: the sample source / code sink side.
    modport slave (
        input  s_axis_data_tdata,
        input  s_axis_data_tvalid,
        output s_axis_data_tready,
        output m_axis_data_tdata,
        output m_axis_data_tvalid
    );

    modport master (
        output s_axis_data_tdata,
        output s_axis_data_tvalid,
        input  s_axis_data_tready,
        input  m_axis_data_tdata,
        input  m_axis_data_tvalid
    );
endinterface

// File: rtl/mash11_dsm.sv
// Second-order MASH 1-1 delta-sigma modulator: WIDTH-bit signed PCM in, signed
// code in -1..+2 out, 1-cycle latency. Define MASH11_DITHER_EN for LFSR carry-in dither.
module mash11_dsm #(
    parameter int WIDTH  = 16,
    parameter int DAC_BW = 4    // must be >= 3 to hold -1..+2
) (
    input  logic            aclk,
    input  logic            arst,
    mash11_dsm_if.slave     io
);

    logic [WIDTH-1:0]  acc1_q, acc1_d;
    logic [WIDTH-1:0]  acc2_q, acc2_d;
    logic              c2_prev_q, c2_prev_d;
    logic [DAC_BW-1:0] code_q, code_d;
    logic              vld_q, vld_d;
    logic              rdy_q;

    logic              accept;
    logic              cin;
    logic [WIDTH-1:0]  u;
    logic [WIDTH:0]    sum1;
    logic [WIDTH:0]    sum2;
    logic [DAC_BW-1:0] y;

    assign accept = io.s_axis_data_tvalid & rdy_q;

    // Flipping the sign bit maps the signed range onto [0, 2^WIDTH).
    assign u = {~io.s_axis_data_tdata[WIDTH-1], io.s_axis_data_tdata[WIDTH-2:0]};

`ifdef MASH11_DITHER_EN
    logic [15:0] lfsr_q, lfsr_d;

    // Galois form of x^16+x^14+x^13+x^11+1, stepped once per accepted sample.
    always_comb begin
        lfsr_d = lfsr_q;
        if (accept) begin
            lfsr_d = lfsr_q[0] ? ((lfsr_q >> 1) ^ 16'hB400) : (lfsr_q >> 1);
        end
    end

    always_ff @(posedge aclk) begin
        if (arst) begin
            lfsr_q <= 16'hACE1;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign cin = lfsr_q[0];
`else
    assign cin = 1'b0;
`endif

    always_comb begin
        sum1 = {1'b0, acc1_q} + {1'b0, u} + {{WIDTH{1'b0}}, cin};
        sum2 = {1'b0, acc2_q} + {1'b0, sum1[WIDTH-1:0]};
        // c1 + c2 - c2_prev; modular DAC_BW arithmetic yields the signed code directly.
        y    = {{(DAC_BW-1){1'b0}}, sum1[WIDTH]}
             + {{(DAC_BW-1){1'b0}}, sum2[WIDTH]}
             - {{(DAC_BW-1){1'b0}}, c2_prev_q};
    end

    always_comb begin
        acc1_d    = acc1_q;
        acc2_d    = acc2_q;
        c2_prev_d = c2_prev_q;
        code_d    = code_q;
        vld_d     = 1'b0;
        if (accept) begin
            acc1_d    = sum1[WIDTH-1:0];
            acc2_d    = sum2[WIDTH-1:0];
            c2_prev_d = sum2[WIDTH];
            code_d    = y;
            vld_d     = 1'b1;
        end
    end

    always_ff @(posedge aclk) begin
        if (arst) begin
            acc1_q    <= '0;
            acc2_q    <= '0;
            c2_prev_q <= 1'b0;
            code_q    <= '0;
            vld_q     <= 1'b0;
            rdy_q     <= 1'b0;
        end else begin
            acc1_q    <= acc1_d;
            acc2_q    <= acc2_d;
            c2_prev_q <= c2_prev_d;
            code_q    <= code_d;
            vld_q     <= vld_d;
            rdy_q     <= 1'b1;
        end
    end

    assign io.s_axis_data_tready = rdy_q;
    assign io.m_axis_data_tdata  = code_q;
    assign io.m_axis_data_tvalid = vld_q;

endmodule

// File: tb/tb_mash11_dsm.sv
// Scoreboard bench for mash11_dsm: directed stimulus pushes hand-derived codes,
// a negedge monitor pops and compares whenever the output is valid.
module tb_mash11_dsm;
    localparam int WIDTH  = 16;
    localparam int DAC_BW = 4;

    logic aclk = 1'b0;
    logic arst = 1'b1;
    always #4 aclk = ~aclk;

    mash11_dsm_if #(.WIDTH(WIDTH), .DAC_BW(DAC_BW)) dif ();

    mash11_dsm #(.WIDTH(WIDTH), .DAC_BW(DAC_BW)) dut (
        .aclk (aclk),
        .arst (arst),
        .io   (dif)
    );

    typedef struct {
        bit exact;
        int val;
    } exp_t;

    exp_t sb_q[$];
    int   got_q[$];
    int   u_q[$];
    int   total = 0;
    int   bad   = 0;

    bit   armed    = 1'b0;
    bit   exp_rdy  = 1'b0;
    bit   exp_mv   = 1'b0;
    bit   rst_edge = 1'b0;
    bit   cur_r    = 1'b1;
    bit   cur_v    = 1'b1;
    exp_t cur_e    = '{1'b0, 0};

    int   pat4[4]  = '{0, 1, 1, 0};
    int   pat7f[3] = '{0, 2, 1};
    int   pat40[10] = '{0, 2, 0, 1, 1, 0, 2, 0, 0, 2};

    function automatic void check(bit ok, string name, int act, int req);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endfunction

    // One clock: account for the inputs live at this edge, then drive the next ones.
    task automatic step(input bit r, input bit v, input logic [WIDTH-1:0] x,
                        input bit ex, input int val);
        @(posedge aclk);
        rst_edge = cur_r;
        if (cur_r) begin
            exp_rdy = 1'b0;
            exp_mv  = 1'b0;
        end else begin
            exp_mv = cur_v && exp_rdy;
            if (exp_mv) sb_q.push_back(cur_e);
            exp_rdy = 1'b1;
        end
        armed = 1'b1;
        #1;
        arst                   = r;
        dif.s_axis_data_tvalid = v;
        dif.s_axis_data_tdata  = x;
        cur_r     = r;
        cur_v     = v;
        cur_e.exact = ex;
        cur_e.val   = val;
    endtask

    // Reset held n edges with tvalid high (samples must be dropped), then one idle cycle.
    task automatic rst_pulse(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b1, 16'h1234, 1'b0, 0);
        step(1'b0, 1'b0, 16'h0000, 1'b0, 0);
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        while (k < 8) begin
            step(1'b0, 1'b0, 16'h0000, 1'b0, 0);
            k++;
        end
        check(sb_q.size() == 0, name, sb_q.size(), 0);
    endtask

    // Monitor
    int hold_val   = 0;
    bit hold_known = 1'b0;
    always @(negedge aclk) begin
        exp_t it;
        int   y;
        if (armed) begin
            y = $signed(dif.m_axis_data_tdata);
            if (rst_edge) begin
                hold_val   = 0;
                hold_known = 1'b1;
            end
            check(dif.s_axis_data_tready === exp_rdy, "tready", int'(dif.s_axis_data_tready), int'(exp_rdy));
            check(dif.m_axis_data_tvalid === exp_mv, "m_tvalid", int'(dif.m_axis_data_tvalid), int'(exp_mv));
            if (dif.m_axis_data_tvalid === 1'b1) begin
                if (sb_q.size() == 0) begin
                    check(1'b0, "unexpected_output", y, 0);
                end else begin
                    it = sb_q.pop_front();
                    got_q.push_back(y);
                    if (it.exact) begin
                        check(y == it.val, "code", y, it.val);
                        hold_val   = it.val;
                        hold_known = 1'b1;
                    end else begin
                        check(y >= -1 && y <= 2, "code_range", y, 0);
                        hold_known = 1'b0;
                    end
                end
            end else if (hold_known) begin
                check(y == hold_val, "code_hold", y, hold_val);
            end
        end
    end

    initial begin
        int   k;
        int   sum_y;
        int   xi;
        real  sum_u;
        real  ws_u;
        int   ws_y;
        real  diff;

        dif.s_axis_data_tvalid = 1'b1;
        dif.s_axis_data_tdata  = 16'h0000;

        // Reset: three edges with arst and tvalid high.
        rst_pulse(2);

        // Midscale continuous.
        got_q.delete();
        for (int n = 0; n < 4096; n++) step(1'b0, 1'b1, 16'h0000, 1'b1, pat4[n % 4]);
        drain("drain_mid");
        sum_y = 0;
        foreach (got_q[i]) sum_y += got_q[i];
        check(sum_y >= 2047 && sum_y <= 2049, "mid_sum", sum_y, 2048);

        // Gapped stream continues the same pattern; state holds through gaps.
        k = 0;
        for (int n = 0; n < 64; n++) begin
            if (n % 2 == 0) begin
                step(1'b0, 1'b1, 16'h0000, 1'b1, pat4[k % 4]);
                k++;
            end else begin
                step(1'b0, 1'b0, 16'h0000, 1'b0, 0);
            end
        end
        drain("drain_gap");

        // Most negative input: all zero codes.
        for (int n = 0; n < 64; n++) step(1'b0, 1'b1, 16'h8000, 1'b1, 0);
        drain("drain_min");

        // Most positive input from a clean state.
        rst_pulse(1);
        got_q.delete();
        for (int n = 0; n < 4096; n++) begin
            if (n < 3) step(1'b0, 1'b1, 16'h7FFF, 1'b1, pat7f[n]);
            else       step(1'b0, 1'b1, 16'h7FFF, 1'b0, 0);
        end
        drain("drain_max");
        sum_y = 0;
        foreach (got_q[i]) sum_y += got_q[i];
        diff = real'(sum_y) - 4096.0 * 65535.0 / 65536.0;
        check(diff <= 2.0 && diff >= -2.0, "max_sum", sum_y, 4096);

        // Reset mid-stream restarts the sequence.
        rst_pulse(1);
        for (int n = 0; n < 10; n++) step(1'b0, 1'b1, 16'h4000, 1'b1, pat40[n]);
        rst_pulse(1);
        for (int n = 0; n < 8; n++) step(1'b0, 1'b1, 16'h0000, 1'b1, pat4[n % 4]);
        drain("drain_rst");

        // Sine: 20 kHz at 8 ns sample period, 5 periods.
        rst_pulse(1);
        got_q.delete();
        u_q.delete();
        for (int n = 0; n < 31250; n++) begin
            xi = $rtoi($floor(30000.0 * $sin(2.0 * 3.14159265358979 * real'(n) / 6250.0) + 0.5));
            u_q.push_back(xi + 32768);
            step(1'b0, 1'b1, xi[15:0], 1'b0, 0);
        end
        drain("drain_sine");
        check(got_q.size() == 31250, "sine_count", got_q.size(), 31250);
        if (got_q.size() == 31250) begin
            sum_y = 0;
            sum_u = 0.0;
            for (int w = 0; w < 125; w++) begin
                ws_y = 0;
                ws_u = 0.0;
                for (int i = w * 250; i < w * 250 + 250; i++) begin
                    ws_y += got_q[i];
                    ws_u += real'(u_q[i]);
                end
                sum_y += ws_y;
                sum_u += ws_u;
                diff = real'(ws_y) - ws_u / 65536.0;
                check(diff <= 2.0 && diff >= -2.0, "sine_track", ws_y, $rtoi(ws_u / 65536.0));
            end
            diff = real'(sum_y) - sum_u / 65536.0;
            check(diff <= 2.0 && diff >= -2.0, "sine_mean", sum_y, $rtoi(sum_u / 65536.0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
